mem_rd_seq: RTL and testbench

//  Memory-operand read sequencer directly upstream of the MEM stage operand swap.
//  Per instruction: issues up to four line reads to the D-cache (two operands, each possibly line-split).

---
 rtl/mem_rd_pkg.sv | 29 ++
 rtl/mem_line_extract.sv | 30 +++
 rtl/mem_rd_seq.sv | 180 ++++++++++++++++++
 tb/tb_mem_rd_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_pkg.sv
// Shared definitions for the memory-operand read sequencer.
//   state_e      : sequencer FSM states
//   LINE_OFS_W   : byte-offset width inside a cache line (16-byte lines)
//   opsize_mask(): operand size code -> byte-enable mask of the 64-bit operand
package mem_rd_pkg;

  localparam int LINE_OFS_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_R1A  = 3'd1,
    ST_R1B  = 3'd2,
    ST_R2A  = 3'd3,
    ST_R2B  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic logic [7:0] opsize_mask(input logic [1:0] opsize);
    logic [7:0] m;
    case (opsize)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_line_extract.sv
// Combinational operand aligner.
//   win_i    : two consecutive cache lines (low line in the low half)
//   ofs_i    : byte offset of the operand start inside the low line
//   opsize_i : operand size code (0=1B .. 3=8B)
//   data_o   : operand, little-endian, bytes above the operand size forced to 0
module mem_line_extract
  import mem_rd_pkg::*;
#(
  parameter int WIN_W = 256,
  parameter int OUT_W = 64
) (
  input  logic [WIN_W-1:0]      win_i,
  input  logic [LINE_OFS_W-1:0] ofs_i,
  input  logic [1:0]            opsize_i,
  output logic [OUT_W-1:0]      data_o
);

  logic [OUT_W-1:0] shifted;
  logic [7:0]       mask;

  always_comb begin
    shifted = OUT_W'(win_i >> {ofs_i, 3'b000});
    mask    = opsize_mask(opsize_i);
    data_o  = '0;
    for (int b = 0; b < OUT_W / 8; b++) begin
      if (mask[b]) data_o[8*b +: 8] = shifted[8*b +: 8];
    end
  end

endmodule

// File: rtl/mem_rd_seq.sv
// Memory-operand read sequencer in front of the MEM-stage operand swap.
// Fetches up to four cache lines per instruction (two operands, each possibly
// line-split), aligns the bytes and holds the front of the pipe until both
// operands are available.
// Ports:
//   clk, clr (async active-low reset), valid_in, flush, stall_in
//   opsize_in, mem_addr1/_end, mem_addr2/_end, mem1_rw, mem2_rw (bit0 = read)
//   rd_req/rd_addr -> cache, rd_ack/rd_data <- cache (data valid with ack)
//   wb_wr_valid    : store commit, invalidates the line buffer
//   mem1_data, mem2_data, data_valid, stall_out -> pipeline
// Optional feature: define MEM_RD_LINEBUF_EN to add a one-entry line buffer
// that satisfies repeated reads of the last fetched line without the cache.
module mem_rd_seq
  import mem_rd_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    valid_in,
  input  logic                    flush,
  input  logic                    stall_in,
  input  logic [1:0]              opsize_in,
  input  logic [ADDR_W-1:0]       mem_addr1,
  input  logic [ADDR_W-1:0]       mem_addr1_end,
  input  logic [ADDR_W-1:0]       mem_addr2,
  input  logic [ADDR_W-1:0]       mem_addr2_end,
  input  logic [1:0]              mem1_rw,
  input  logic [1:0]              mem2_rw,
  output logic                    rd_req,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_ack,
  input  logic [8*LINE_BYTES-1:0] rd_data,
  input  logic                    wb_wr_valid,
  output logic [DATA_W-1:0]       mem1_data,
  output logic [DATA_W-1:0]       mem2_data,
  output logic                    data_valid,
  output logic                    stall_out
);

  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int LN_W   = ADDR_W - LINE_OFS_W;

  state_e              st_q, st_d;
  logic                rd1_q, rd2_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   a1_q, e1_q, a2_q, e2_q;
  logic [2*LINE_W-1:0] win1_q, win2_q;

  logic              in_rx, accept, split1, split2, hit, done_req;
  logic [LN_W-1:0]   req_line;
  logic [LINE_W-1:0] line_data;
  logic [DATA_W-1:0] ext1, ext2;
  logic [1:0]        unused_rw;

  assign unused_rw = {mem1_rw[1], mem2_rw[1]};

  assign split1 = a1_q[ADDR_W-1:LINE_OFS_W] != e1_q[ADDR_W-1:LINE_OFS_W];
  assign split2 = a2_q[ADDR_W-1:LINE_OFS_W] != e2_q[ADDR_W-1:LINE_OFS_W];
  assign accept = (st_q == ST_IDLE) & valid_in & ~flush;

  always_comb begin
    in_rx    = 1'b0;
    req_line = '0;
    case (st_q)
      ST_R1A: begin in_rx = 1'b1; req_line = a1_q[ADDR_W-1:LINE_OFS_W]; end
      ST_R1B: begin in_rx = 1'b1; req_line = e1_q[ADDR_W-1:LINE_OFS_W]; end
      ST_R2A: begin in_rx = 1'b1; req_line = a2_q[ADDR_W-1:LINE_OFS_W]; end
      ST_R2B: begin in_rx = 1'b1; req_line = e2_q[ADDR_W-1:LINE_OFS_W]; end
      default: ;
    endcase
  end

`ifdef MEM_RD_LINEBUF_EN
  logic              lb_valid_q;
  logic [LN_W-1:0]   lb_tag_q;
  logic [LINE_W-1:0] lb_data_q;

  // A committing store may target the buffered line, so a hit in that cycle
  // is refused and the request falls through to the cache.
  assign hit = in_rx & lb_valid_q & (lb_tag_q == req_line) & ~wb_wr_valid;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                      lb_valid_q <= 1'b0;
    else if (flush || wb_wr_valid) lb_valid_q <= 1'b0;
    else if (rd_req && rd_ack)     lb_valid_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rd_req && rd_ack && !flush && !wb_wr_valid) begin
      lb_tag_q  <= req_line;
      lb_data_q <= rd_data;
    end
  end

  assign line_data = hit ? lb_data_q : rd_data;
`else
  logic unused_wb;
  assign unused_wb = wb_wr_valid;
  assign hit       = 1'b0;
  assign line_data = rd_data;
`endif

  assign rd_req   = in_rx & ~hit;
  assign rd_addr  = {req_line, {LINE_OFS_W{1'b0}}};
  assign done_req = (rd_req & rd_ack) | hit;

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (valid_in) st_d = mem1_rw[0] ? ST_R1A : (mem2_rw[0] ? ST_R2A : ST_DONE);
      ST_R1A:  if (done_req) st_d = split1 ? ST_R1B : (rd2_q ? ST_R2A : ST_DONE);
      ST_R1B:  if (done_req) st_d = rd2_q ? ST_R2A : ST_DONE;
      ST_R2A:  if (done_req) st_d = split2 ? ST_R2B : ST_DONE;
      ST_R2B:  if (done_req) st_d = ST_DONE;
      ST_DONE: if (!stall_in) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    // Flush overrides every transition, including an ack in the same cycle.
    if (flush) st_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_q  <= ST_IDLE;
      rd1_q <= 1'b0;
      rd2_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        rd1_q <= mem1_rw[0];
        rd2_q <= mem2_rw[0];
      end
    end
  end

  // Instruction fields and line windows carry no reset; the read flags gate
  // the operand outputs until a window has been filled.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= opsize_in;
      a1_q <= mem_addr1;
      e1_q <= mem_addr1_end;
      a2_q <= mem_addr2;
      e2_q <= mem_addr2_end;
    end
    if (done_req && !flush) begin
      case (st_q)
        ST_R1A:  win1_q[LINE_W-1:0]        <= line_data;
        ST_R1B:  win1_q[2*LINE_W-1:LINE_W] <= line_data;
        ST_R2A:  win2_q[LINE_W-1:0]        <= line_data;
        ST_R2B:  win2_q[2*LINE_W-1:LINE_W] <= line_data;
        default: ;
      endcase
    end
  end

  mem_line_extract #(.WIN_W(2*LINE_W), .OUT_W(DATA_W)) u_ext1 (
    .win_i    (win1_q),
    .ofs_i    (a1_q[LINE_OFS_W-1:0]),
    .opsize_i (op_q),
    .data_o   (ext1)
  );

  mem_line_extract #(.WIN_W(2*LINE_W), .OUT_W(DATA_W)) u_ext2 (
    .win_i    (win2_q),
    .ofs_i    (a2_q[LINE_OFS_W-1:0]),
    .opsize_i (op_q),
    .data_o   (ext2)
  );

  assign mem1_data  = rd1_q ? ext1 : '0;
  assign mem2_data  = rd2_q ? ext2 : '0;
  assign data_valid = (st_q == ST_DONE);
  assign stall_out  = in_rx | ((st_q == ST_DONE) & stall_in) |
                      ((st_q == ST_IDLE) & valid_in & (mem1_rw[0] | mem2_rw[0]));

endmodule

// File: tb/tb_mem_rd_seq.sv
`timescale 1ns/1ps
module tb_mem_rd_seq;

  logic         clk = 1'b0;
  logic         clr, valid_in, flush, stall_in;
  logic [1:0]   opsize_in;
  logic [31:0]  mem_addr1, mem_addr1_end, mem_addr2, mem_addr2_end;
  logic [1:0]   mem1_rw, mem2_rw;
  logic         rd_req, rd_ack, wb_wr_valid;
  logic [31:0]  rd_addr;
  logic [127:0] rd_data;
  logic [63:0]  mem1_data, mem2_data;
  logic         data_valid, stall_out;

  always #5 clk = ~clk;

  mem_rd_seq dut (
    .clk(clk), .clr(clr), .valid_in(valid_in), .flush(flush), .stall_in(stall_in),
    .opsize_in(opsize_in), .mem_addr1(mem_addr1), .mem_addr1_end(mem_addr1_end),
    .mem_addr2(mem_addr2), .mem_addr2_end(mem_addr2_end), .mem1_rw(mem1_rw), .mem2_rw(mem2_rw),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wb_wr_valid(wb_wr_valid), .mem1_data(mem1_data), .mem2_data(mem2_data),
    .data_valid(data_valid), .stall_out(stall_out)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] req_log[$];
  int resp_wait = 0;
  bit resp_rand = 1'b0;
  bit mix = 1'b0;

  // Backing memory: a plain byte ramp, or a scrambled pattern for random runs.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mix) return a[7:0] ^ (a[15:8] * 8'd29) ^ 8'h5A;
    return a[7:0];
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = (a / 32'd16) * 32'd16;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = mem_byte(base + 32'(i));
    return l;
  endfunction

  function automatic logic [63:0] model_op(input logic [31:0] a, input logic [1:0] op);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < (1 << op); k++) d[8*k +: 8] = mem_byte(a + 32'(k));
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Cache model: acks after a wait, logs every accepted line address and
  // checks that the request address holds while waiting.
  initial begin : responder
    bit          pend;
    int          wcnt;
    logic [31:0] cur;
    pend = 1'b0; wcnt = 0; cur = '0;
    rd_ack = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk); #1;
      rd_ack = 1'b0;
      if (rd_req === 1'b1) begin
        if (!pend) begin
          pend = 1'b1;
          cur  = rd_addr;
          wcnt = resp_rand ? int'($urandom_range(0, 3)) : resp_wait;
        end else begin
          chk("rd_addr_stable", 64'(rd_addr), 64'(cur));
        end
        if (wcnt == 0) begin
          rd_ack  = 1'b1;
          rd_data = line_of(rd_addr);
          req_log.push_back(rd_addr);
          pend = 1'b0;
        end else begin
          wcnt--;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply(input logic [1:0] op, input logic [31:0] a1, input logic [31:0] a2,
                       input logic r1, input logic r2);
    opsize_in     = op;
    mem_addr1     = a1;
    mem_addr1_end = a1 + (32'd1 << op) - 32'd1;
    mem_addr2     = a2;
    mem_addr2_end = a2 + (32'd1 << op) - 32'd1;
    mem1_rw       = {1'b0, r1};
    mem2_rw       = {1'b0, r2};
    valid_in      = 1'b1;
  endtask

  task automatic wait_dv(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      valid_in = 1'b0;
      lat++;
    end while (!data_valid && lat < 60);
    checks++;
    if (!data_valid) begin
      errors++;
      $display("FAIL dv_timeout: data_valid %0b after %0d cycles, expected 1", data_valid, lat);
    end
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [31:0] a1, input logic [31:0] a2,
                           input logic r1, input logic r2,
                           output logic [63:0] d1, output logic [63:0] d2, output int lat);
    req_log.delete();
    apply(op, a1, a2, r1, r2);
    wait_dv(lat);
    d1 = mem1_data;
    d2 = mem2_data;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a1, a2;
    logic        r1, r2;
    logic [63:0] e1, e2;
    int          nreq, lat;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    logic [63:0] d1, d2;
    int lat;
    logic [31:0] exp_q[$];

    clr = 1'b0; valid_in = 1'b0; flush = 1'b0; stall_in = 1'b0; wb_wr_valid = 1'b0;
    opsize_in = '0; mem_addr1 = '0; mem_addr1_end = '0; mem_addr2 = '0; mem_addr2_end = '0;
    mem1_rw = '0; mem2_rw = '0;

    vecs[0] = '{2'd3, 32'h0000, 32'h0000, 1'b0, 1'b0, 64'h0, 64'h0, 0, 1};
    vecs[1] = '{2'd2, 32'h1004, 32'h0000, 1'b1, 1'b0, 64'h07060504, 64'h0, 1, 2};
    vecs[2] = '{2'd3, 32'h200C, 32'h0000, 1'b1, 1'b0, 64'h131211100F0E0D0C, 64'h0, 2, 3};
    vecs[3] = '{2'd0, 32'h0105, 32'h03FF, 1'b1, 1'b1, 64'h05, 64'hFF, 2, 3};
    vecs[4] = '{2'd1, 32'h004F, 32'h0082, 1'b1, 1'b1, 64'h504F, 64'h8382, 3, 4};
    vecs[5] = '{2'd3, 32'h0000, 32'h0408, 1'b0, 1'b1, 64'h0, 64'h0F0E0D0C0B0A0908, 1, 2};
    vecs[6] = '{2'd2, 32'h30FE, 32'h300D, 1'b1, 1'b1, 64'h0100FFFE, 64'h100F0E0D, 4, 5};
    vecs[7] = '{2'd3, 32'h5000, 32'h5008, 1'b1, 1'b1, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 2, 3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_req", 64'(rd_req), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_mem1", mem1_data, 64'd0);
    chk("rst_mem2", mem2_data, 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    clr = 1'b1;
    @(negedge clk);

    // Single aligned read with two wait cycles
    resp_wait = 2;
    run_instr(2'd2, 32'h1004, 32'h0, 1'b1, 1'b0, d1, d2, lat);
    chk_int("t2_nreq", req_log.size(), 1);
    chk("t2_addr", 64'(req_log[0]), 64'h1000);
    chk("t2_mem1", d1, 64'h07060504);
    chk("t2_mem2", d2, 64'h0);
    chk_int("t2_lat", lat, 4);

    // Line-split operand: request order
    resp_wait = 1;
    run_instr(2'd3, 32'h200C, 32'h0, 1'b1, 1'b0, d1, d2, lat);
    chk_int("t3_nreq", req_log.size(), 2);
    chk("t3_addr0", 64'(req_log[0]), 64'h2000);
    chk("t3_addr1", 64'(req_log[1]), 64'h2010);
    chk("t3_mem1", d1, 64'h131211100F0E0D0C);

    // Table of directed vectors, immediate acks
    resp_wait = 0;
    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].r1, vecs[i].r2, d1, d2, lat);
      chk($sformatf("vec%0d_mem1", i), d1, vecs[i].e1);
      chk($sformatf("vec%0d_mem2", i), d2, vecs[i].e2);
      chk_int($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
`ifndef MEM_RD_LINEBUF_EN
      chk_int($sformatf("vec%0d_nreq", i), req_log.size(), vecs[i].nreq);
`endif
    end

    // Both operands, split op2, stall_in held three cycles in DONE
    resp_wait = 1;
    apply(2'd2, 32'h0104, 32'h020E, 1'b1, 1'b1);
    stall_in = 1'b1;
    wait_dv(lat);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("t4_dv%0d", i), 64'(data_valid), 64'd1);
      chk($sformatf("t4_stall%0d", i), 64'(stall_out), 64'd1);
      chk($sformatf("t4_mem1_%0d", i), mem1_data, 64'h07060504);
      chk($sformatf("t4_mem2_%0d", i), mem2_data, 64'h11100F0E);
    end
    stall_in = 1'b0;
    @(negedge clk);
    chk("t4_idle_dv", 64'(data_valid), 64'd0);
    chk("t4_idle_stall", 64'(stall_out), 64'd0);

    // Flush in R1B while the cache acks
    resp_wait = 0;
    apply(2'd3, 32'h200C, 32'h0300, 1'b1, 1'b1);
    @(negedge clk);
    valid_in = 1'b0;
    chk("t5_r1a_addr", 64'(rd_addr), 64'h2000);
    @(negedge clk);
    chk("t5_r1b_addr", 64'(rd_addr), 64'h2010);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_rd_req", 64'(rd_req), 64'd0);
    chk("t5_stall", 64'(stall_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_dv%0d", i), 64'(data_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("t5_req%0d", i), 64'(rd_req), 64'd0);
    end

    // Asynchronous reset while waiting in R2A
    resp_wait = 5;
    apply(2'd3, 32'h0, 32'h0600, 1'b0, 1'b1);
    @(negedge clk);
    valid_in = 1'b0;
    chk("t5c_req", 64'(rd_req), 64'd1);
    chk("t5c_addr", 64'(rd_addr), 64'h0600);
    #2 clr = 1'b0;
    #1;
    chk("t5c_rst_req", 64'(rd_req), 64'd0);
    chk("t5c_rst_addr", 64'(rd_addr), 64'd0);
    chk("t5c_rst_dv", 64'(data_valid), 64'd0);
    chk("t5c_rst_stall", 64'(stall_out), 64'd0);
    chk("t5c_rst_mem1", mem1_data, 64'd0);
    chk("t5c_rst_mem2", mem2_data, 64'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("t5c_after_req", 64'(rd_req), 64'd0);

    // Randomized instructions against the byte-memory model
    mix = 1'b1;
    resp_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] a1, a2;
      logic        r1, r2;
      op = 2'($urandom_range(0, 3));
      a1 = 32'($urandom_range(0, 32'hFFFF));
      a2 = 32'($urandom_range(0, 32'hFFFF));
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      exp_q.delete();
      if (r1) begin
        exp_q.push_back((a1 / 32'd16) * 32'd16);
        if (a1 / 32'd16 != (a1 + (32'd1 << op) - 32'd1) / 32'd16)
          exp_q.push_back(((a1 + (32'd1 << op) - 32'd1) / 32'd16) * 32'd16);
      end
      if (r2) begin
        exp_q.push_back((a2 / 32'd16) * 32'd16);
        if (a2 / 32'd16 != (a2 + (32'd1 << op) - 32'd1) / 32'd16)
          exp_q.push_back(((a2 + (32'd1 << op) - 32'd1) / 32'd16) * 32'd16);
      end
      run_instr(op, a1, a2, r1, r2, d1, d2, lat);
      chk($sformatf("rnd%0d_mem1", n), d1, r1 ? model_op(a1, op) : 64'h0);
      chk($sformatf("rnd%0d_mem2", n), d2, r2 ? model_op(a2, op) : 64'h0);
`ifndef MEM_RD_LINEBUF_EN
      chk_int($sformatf("rnd%0d_nreq", n), req_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < req_log.size(); k++)
        chk($sformatf("rnd%0d_addr%0d", n, k), 64'(req_log[k]), 64'(exp_q[k]));
`endif
    end
    mix = 1'b0;
    resp_rand = 1'b0;

`ifdef MEM_RD_LINEBUF_EN
    // Line buffer: repeated line hits, store commit forces a refetch
    resp_wait = 1;
    wb_wr_valid = 1'b1;
    @(negedge clk);
    wb_wr_valid = 1'b0;
    run_instr(2'd2, 32'h3004, 32'h0, 1'b1, 1'b0, d1, d2, lat);
    chk_int("t6_first_nreq", req_log.size(), 1);
    run_instr(2'd2, 32'h3008, 32'h0, 1'b1, 1'b0, d1, d2, lat);
    chk_int("t6_hit_nreq", req_log.size(), 0);
    chk("t6_hit_mem1", d1, 64'h0B0A0908);
    wb_wr_valid = 1'b1;
    @(negedge clk);
    wb_wr_valid = 1'b0;
    run_instr(2'd2, 32'h3008, 32'h0, 1'b1, 1'b0, d1, d2, lat);
    chk_int("t6_inval_nreq", req_log.size(), 1);
    chk("t6_inval_mem1", d1, 64'h0B0A0908);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
